// File: rtl/ball_pkg.sv
// Shared types, limits and the per-axis step helper for the bouncing-ball motion block.
package ball_pkg;

  localparam int COORD_W = 11;
  localparam logic [2:0] SPEED_MIN = 3'd1;
  localparam logic [2:0] SPEED_MAX = 3'd4;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dirNeg;
  } axis_t;

  // One extra headroom bit keeps pos+speed and lo+speed from wrapping before the bound compare.
  function automatic axis_t stepAxis(input logic [COORD_W-1:0] pos,
                                     input logic               dirNeg,
                                     input logic [2:0]         speed,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    axis_t            res;
    logic [COORD_W:0] spd;
    logic [COORD_W:0] sum;
    logic [COORD_W:0] floorLim;
    spd      = {{(COORD_W-2){1'b0}}, speed};
    sum      = {1'b0, pos} + spd;
    floorLim = {1'b0, lo} + spd;
    res.pos    = pos;
    res.dirNeg = dirNeg;
    if (!dirNeg) begin
      if (sum >= {1'b0, hi}) begin
        res.pos    = hi;
        res.dirNeg = 1'b1;
      end else begin
        res.pos = sum[COORD_W-1:0];
      end
    end else begin
      if ({1'b0, pos} <= floorLim) begin
        res.pos    = lo;
        res.dirNeg = 1'b0;
      end else begin
        res.pos = pos - spd[COORD_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ball_motion_key_debounce.sv
// Pushbutton front end: 2-FF synchroniser, level debouncer, and a one-cycle press pulse
// on each accepted high-to-low transition.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic key_i,
  output logic press_o
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Everything resets to the released level so reset release never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ball_motion.sv
// Bouncing-ball position generator: steps the centre on every motion tick, reflects off
// the bounds, and takes pause/run and speed up/down commands from three pushbuttons.
module ball_motion
  import ball_pkg::*;
#(
  parameter int TICK_DIV  = 1258750,
  parameter int DB_CYCLES = 500000,
  parameter int X_MIN     = 30,
  parameter int X_MAX     = 610,
  parameter int Y_MIN     = 30,
  parameter int Y_MAX     = 450,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_key_0,
  input  logic               i_key_1,
  input  logic               i_key_2,
  output logic [COORD_W-1:0] o_cx,
  output logic [COORD_W-1:0] o_cy,
  output logic [2:0]         o_speed,
  output logic               o_paused,
  output logic               o_update
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic               pressRun, pressUp, pressDown;
  logic               tick;
  logic [TICK_W-1:0]  tickCnt_q, tickCnt_d;
  state_e             state_q, state_d;
  logic [2:0]         speed_q, speed_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic               xNeg_q, xNeg_d, yNeg_q, yNeg_d;
  logic               update_q, update_d;
  axis_t              xStep, yStep;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) uKey0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .key_i   (i_key_0),
    .press_o (pressRun)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) uKey1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .key_i   (i_key_1),
    .press_o (pressUp)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) uKey2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .key_i   (i_key_2),
    .press_o (pressDown)
  );

  assign tick  = (tickCnt_q == TICK_LAST);
  assign xStep = stepAxis(cx_q, xNeg_q, speed_q, COORD_W'(X_MIN), COORD_W'(X_MAX));
  assign yStep = stepAxis(cy_q, yNeg_q, speed_q, COORD_W'(Y_MIN), COORD_W'(Y_MAX));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tickCnt_q <= '0;
      state_q   <= RUN;
      speed_q   <= SPEED_MIN;
      cx_q      <= COORD_W'(X_INIT);
      cy_q      <= COORD_W'(Y_INIT);
      xNeg_q    <= 1'b0;
      yNeg_q    <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      tickCnt_q <= tickCnt_d;
      state_q   <= state_d;
      speed_q   <= speed_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      xNeg_q    <= xNeg_d;
      yNeg_q    <= yNeg_d;
      update_q  <= update_d;
    end
  end

  // The move reads state_q/speed_q, so a toggle or speed press landing on a tick acts next tick.
  always_comb begin
    tickCnt_d = tick ? '0 : tickCnt_q + TICK_W'(1);
    state_d   = state_q;
    speed_d   = speed_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    xNeg_d    = xNeg_q;
    yNeg_d    = yNeg_q;
    update_d  = 1'b0;

    if (pressRun) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end

    if (pressUp && !pressDown && speed_q != SPEED_MAX) begin
      speed_d = speed_q + 3'd1;
    end else if (pressDown && !pressUp && speed_q != SPEED_MIN) begin
      speed_d = speed_q - 3'd1;
    end

    if (tick && state_q == RUN) begin
      cx_d     = xStep.pos;
      xNeg_d   = xStep.dirNeg;
      cy_d     = yStep.pos;
      yNeg_d   = yStep.dirNeg;
      update_d = 1'b1;
    end
  end

  assign o_cx     = cx_q;
  assign o_cy     = cy_q;
  assign o_speed  = speed_q;
  assign o_paused = (state_q == PAUSE);
  assign o_update = update_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with an 8-cycle tick and 4-sample debounce; each task
// drives one scenario on a tick-aligned timeline and checks hand-computed positions.
module tb_ball_motion;

  logic        clk = 1'b0;
  logic        rstN;
  logic        key0, key1, key2;
  logic [10:0] cx, cy;
  logic [2:0]  speed;
  logic        paused, update;
  int          checks = 0;
  int          errors = 0;

  ball_motion #(
    .TICK_DIV  (8),
    .DB_CYCLES (4)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rstN),
    .i_key_0  (key0),
    .i_key_1  (key1),
    .i_key_2  (key2),
    .o_cx     (cx),
    .o_cy     (cy),
    .o_speed  (speed),
    .o_paused (paused),
    .o_update (update)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the masked keys low for lowCycles edges, then released for highCycles edges.
  task automatic applyStimulus(input logic [2:0] mask, input int lowCycles, input int highCycles);
    key0 = ~mask[0];
    key1 = ~mask[1];
    key2 = ~mask[2];
    waitEdges(lowCycles);
    key0 = 1'b1;
    key1 = 1'b1;
    key2 = 1'b1;
    waitEdges(highCycles);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    key0 = 1'b1;
    key1 = 1'b1;
    key2 = 1'b1;
    waitEdges(3);
    checks++; if (cx !== 11'd320) begin errors++; $display("[TB] FAIL reset_cx got %0d want 320", cx); end
    checks++; if (cy !== 11'd240) begin errors++; $display("[TB] FAIL reset_cy got %0d want 240", cy); end
    checks++; if (speed !== 3'd1) begin errors++; $display("[TB] FAIL reset_speed got %0d want 1", speed); end
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL reset_paused got %b want 0", paused); end
    checks++; if (update !== 1'b0) begin errors++; $display("[TB] FAIL reset_update got %b want 0", update); end
    rstN = 1'b1;
  endtask

  task automatic test_first_tick();
    waitEdges(7);
    checks++; if (update !== 1'b0) begin errors++; $display("[TB] FAIL early_update got %b want 0", update); end
    checks++; if (cx !== 11'd320) begin errors++; $display("[TB] FAIL early_cx got %0d want 320", cx); end
    waitEdges(1);
    checks++; if (update !== 1'b1) begin errors++; $display("[TB] FAIL tick1_update got %b want 1", update); end
    checks++; if (cx !== 11'd321) begin errors++; $display("[TB] FAIL tick1_cx got %0d want 321", cx); end
    checks++; if (cy !== 11'd241) begin errors++; $display("[TB] FAIL tick1_cy got %0d want 241", cy); end
    waitEdges(1);
    checks++; if (update !== 1'b0) begin errors++; $display("[TB] FAIL pulse_width got %b want 0", update); end
    waitEdges(7);
    checks++; if (cx !== 11'd322) begin errors++; $display("[TB] FAIL tick2_cx got %0d want 322", cx); end
  endtask

  task automatic test_speed_up();
    applyStimulus(3'b010, 6, 10);
    checks++; if (speed !== 3'd2) begin errors++; $display("[TB] FAIL up1_speed got %0d want 2", speed); end
    checks++; if (cx !== 11'd326) begin errors++; $display("[TB] FAIL up1_cx got %0d want 326", cx); end
    applyStimulus(3'b010, 6, 10);
    applyStimulus(3'b010, 6, 10);
    checks++; if (speed !== 3'd4) begin errors++; $display("[TB] FAIL up3_speed got %0d want 4", speed); end
    checks++; if (cx !== 11'd340) begin errors++; $display("[TB] FAIL up3_cx got %0d want 340", cx); end
    checks++; if (cy !== 11'd260) begin errors++; $display("[TB] FAIL up3_cy got %0d want 260", cy); end
  endtask

  task automatic test_x_bounce();
    waitEdges(48 * 8);
    checks++; if (cx !== 11'd532) begin errors++; $display("[TB] FAIL ymax_cx got %0d want 532", cx); end
    checks++; if (cy !== 11'd450) begin errors++; $display("[TB] FAIL ymax_cy got %0d want 450", cy); end
    waitEdges(19 * 8);
    checks++; if (cx !== 11'd608) begin errors++; $display("[TB] FAIL pre_xmax_cx got %0d want 608", cx); end
    checks++; if (cy !== 11'd374) begin errors++; $display("[TB] FAIL pre_xmax_cy got %0d want 374", cy); end
    waitEdges(8);
    checks++; if (cx !== 11'd610) begin errors++; $display("[TB] FAIL xmax_cx got %0d want 610", cx); end
    checks++; if (update !== 1'b1) begin errors++; $display("[TB] FAIL xmax_update got %b want 1", update); end
    waitEdges(8);
    checks++; if (cx !== 11'd606) begin errors++; $display("[TB] FAIL xback_cx got %0d want 606", cx); end
    checks++; if (cy !== 11'd366) begin errors++; $display("[TB] FAIL xback_cy got %0d want 366", cy); end
  endtask

  task automatic test_y_bounce();
    waitEdges(83 * 8);
    checks++; if (cy !== 11'd34) begin errors++; $display("[TB] FAIL pre_ymin_cy got %0d want 34", cy); end
    checks++; if (cx !== 11'd274) begin errors++; $display("[TB] FAIL pre_ymin_cx got %0d want 274", cx); end
    waitEdges(8);
    checks++; if (cy !== 11'd30) begin errors++; $display("[TB] FAIL ymin_cy got %0d want 30", cy); end
    waitEdges(8);
    checks++; if (cy !== 11'd34) begin errors++; $display("[TB] FAIL yback_cy got %0d want 34", cy); end
    checks++; if (cx !== 11'd266) begin errors++; $display("[TB] FAIL yback_cx got %0d want 266", cx); end
  endtask

  task automatic test_pause();
    int updates;
    applyStimulus(3'b001, 6, 10);
    checks++; if (paused !== 1'b1) begin errors++; $display("[TB] FAIL pause_flag got %b want 1", paused); end
    checks++; if (cx !== 11'd266) begin errors++; $display("[TB] FAIL pause_cx got %0d want 266", cx); end
    updates = 0;
    for (int i = 0; i < 24; i++) begin
      waitEdges(1);
      if (update === 1'b1) updates++;
    end
    checks++; if (updates !== 0) begin errors++; $display("[TB] FAIL pause_updates got %0d want 0", updates); end
    checks++; if (cy !== 11'd34) begin errors++; $display("[TB] FAIL pause_cy got %0d want 34", cy); end
    applyStimulus(3'b001, 6, 10);
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL resume_flag got %b want 0", paused); end
    checks++; if (cx !== 11'd258) begin errors++; $display("[TB] FAIL resume_cx got %0d want 258", cx); end
    checks++; if (cy !== 11'd42) begin errors++; $display("[TB] FAIL resume_cy got %0d want 42", cy); end
  endtask

  task automatic test_speed_down();
    applyStimulus(3'b010, 6, 10);
    checks++; if (speed !== 3'd4) begin errors++; $display("[TB] FAIL up_sat_speed got %0d want 4", speed); end
    for (int i = 0; i < 5; i++) applyStimulus(3'b100, 6, 10);
    checks++; if (speed !== 3'd1) begin errors++; $display("[TB] FAIL down_sat_speed got %0d want 1", speed); end
    checks++; if (cx !== 11'd234) begin errors++; $display("[TB] FAIL down_cx got %0d want 234", cx); end
    checks++; if (cy !== 11'd66) begin errors++; $display("[TB] FAIL down_cy got %0d want 66", cy); end
    applyStimulus(3'b110, 6, 10);
    checks++; if (speed !== 3'd1) begin errors++; $display("[TB] FAIL both_speed got %0d want 1", speed); end
    checks++; if (cx !== 11'd232) begin errors++; $display("[TB] FAIL both_cx got %0d want 232", cx); end
  endtask

  // Shifted one cycle so the speed-up press event lands on the tick cycle itself.
  task automatic test_back_to_back();
    waitEdges(1);
    key1 = 1'b0;
    waitEdges(6);
    key1 = 1'b1;
    waitEdges(1);
    checks++; if (speed !== 3'd2) begin errors++; $display("[TB] FAIL coinc_speed got %0d want 2", speed); end
    checks++; if (cx !== 11'd231) begin errors++; $display("[TB] FAIL coinc_cx got %0d want 231", cx); end
    checks++; if (cy !== 11'd69) begin errors++; $display("[TB] FAIL coinc_cy got %0d want 69", cy); end
    waitEdges(8);
    checks++; if (cx !== 11'd229) begin errors++; $display("[TB] FAIL after_coinc_cx got %0d want 229", cx); end
    waitEdges(8);
  endtask

  task automatic test_glitch();
    applyStimulus(3'b010, 3, 13);
    checks++; if (speed !== 3'd2) begin errors++; $display("[TB] FAIL glitch_speed got %0d want 2", speed); end
    checks++; if (cx !== 11'd223) begin errors++; $display("[TB] FAIL glitch_cx got %0d want 223", cx); end
    checks++; if (cy !== 11'd77) begin errors++; $display("[TB] FAIL glitch_cy got %0d want 77", cy); end
  endtask

  task automatic test_reset_mid();
    waitEdges(3);
    key1 = 1'b0;
    waitEdges(3);
    rstN = 1'b0;
    #1;
    checks++; if (cx !== 11'd320) begin errors++; $display("[TB] FAIL midrst_cx got %0d want 320", cx); end
    checks++; if (cy !== 11'd240) begin errors++; $display("[TB] FAIL midrst_cy got %0d want 240", cy); end
    checks++; if (speed !== 3'd1) begin errors++; $display("[TB] FAIL midrst_speed got %0d want 1", speed); end
    checks++; if (update !== 1'b0) begin errors++; $display("[TB] FAIL midrst_update got %b want 0", update); end
    key1 = 1'b1;
    waitEdges(2);
    rstN = 1'b1;
    waitEdges(8);
    checks++; if (update !== 1'b1) begin errors++; $display("[TB] FAIL postrst_update got %b want 1", update); end
    checks++; if (cx !== 11'd321) begin errors++; $display("[TB] FAIL postrst_cx got %0d want 321", cx); end
    checks++; if (speed !== 3'd1) begin errors++; $display("[TB] FAIL postrst_speed got %0d want 1", speed); end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_speed_up();
    test_x_bounce();
    test_y_bounce();
    test_pause();
    test_speed_down();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
